// File: rtl/dircc_mem_pkg.sv
// Shared definitions for the node processing-memory readers and memory wrappers.
// Holds the memory geometry constants and the reader FSM state encoding.
package dircc_mem_pkg;

  // Halfword address width and data width of the processing memory second port.
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned DATA_W    = 16;
  // Memory depth in halfwords; reader addresses wrap at this value.
  localparam int unsigned MEM_WORDS = 20480;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/dircc_sync_fifo.sv
// Small synchronous FIFO buffering memory read data ahead of the stream port.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (empties the FIFO)
//   push_i   write data_i this cycle
//   data_i   write data
//   pop_i    drop the head entry this cycle
//   data_o   head entry (valid when count_o != 0)
//   count_o  number of entries held
// Push and pop may occur in the same cycle, including when full; the caller
// guarantees it never pushes into a full FIFO without popping.
module dircc_sync_fifo #(
  parameter int unsigned DATA_W     = dircc_mem_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              push_i,
  input  logic [DATA_W-1:0]                 data_i,
  input  logic                              pop_i,
  output logic [DATA_W-1:0]                 data_o,
  output logic [$clog2(FIFO_DEPTH):0]       count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dircc_processing_mem_reader.sv
// Avalon-MM read master that drains a message from processing memory and emits
// it as an Avalon-ST packet.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_addr/cmd_len  command from the node send logic
//   mem_*                              latency-1 read port of processing memory
//   st_data/st_valid/st_ready/st_sop/st_eop  outgoing packet stream
//   done/err                           completion pulse; err marks zero length
module dircc_processing_mem_reader #(
  parameter int unsigned ADDR_W     = dircc_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W     = dircc_mem_pkg::DATA_W,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned MEM_WORDS  = dircc_mem_pkg::MEM_WORDS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_write,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop,
  output logic                done,
  output logic                err
);

  import dircc_mem_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_left_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic              inflight_q;
  logic              err_q;

  logic [CntW-1:0]   fifo_count;
  logic [DATA_W-1:0] fifo_head;

  logic accept;
  logic credit_ok;
  logic strobe;
  logic push;
  logic beat_valid;
  logic pop;
  logic last_beat;
  logic [ADDR_W-1:0] addr_next;

  // Everything visible is forced low while reset is asserted, so a reset in
  // the middle of a packet never leaks a beat, strobe or done.
  assign accept     = (state_q == StIdle) && cmd_valid && !reset;
  // Pending read plus held words must stay below depth: the returned word is
  // pushed unconditionally, so this is what keeps the FIFO from overflowing.
  assign credit_ok  = (CntW'(inflight_q) + fifo_count) < CntW'(FIFO_DEPTH);
  assign strobe     = (state_q == StIssue) && credit_ok && !reset;
  assign push       = inflight_q && !reset;
  assign beat_valid = (fifo_count != '0) && !reset;
  assign pop        = beat_valid && st_ready;
  assign last_beat  = (beat_cnt_q == len_q - LEN_W'(1));
  assign addr_next  = (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);

  dircc_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (mem_readdata),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      issue_left_q <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      inflight_q <= strobe;
      if (pop) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q       <= cmd_addr;
            len_q        <= cmd_len;
            issue_left_q <= cmd_len;
            beat_cnt_q   <= '0;
            err_q        <= (cmd_len == '0);
            state_q      <= (cmd_len == '0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          if (strobe) begin
            addr_q       <= addr_next;
            issue_left_q <= issue_left_q - LEN_W'(1);
            if (issue_left_q == LEN_W'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // The EOP beat is the last word issued, so its handshake also means
          // the FIFO empties and nothing remains in flight.
          if (pop && last_beat) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready      = (state_q == StIdle) && !reset;
  assign mem_address    = reset ? '0 : addr_q;
  assign mem_chipselect = strobe;
  assign mem_clken      = 1'b1;
  assign mem_byteenable = '1;
  assign mem_write      = 1'b0;

  assign st_valid = beat_valid;
  assign st_data  = beat_valid ? fifo_head : '0;
  assign st_sop   = beat_valid && (beat_cnt_q == '0);
  assign st_eop   = beat_valid && last_beat;

  assign done = (state_q == StDone) && !reset;
  assign err  = done && err_q;

endmodule

// File: tb/tb_dircc_processing_mem_reader.sv
// Directed testbench for dircc_processing_mem_reader with a latency-1 memory
// model and a stream monitor sampling on the falling edge.
module tb_dircc_processing_mem_reader;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 8;
  localparam int unsigned MW = 20480;
  localparam int unsigned FD = 4;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_clken;
  logic [1:0]    mem_byteenable;
  logic          mem_write;
  logic [DW-1:0] mem_readdata;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready;
  logic          st_sop;
  logic          st_eop;
  logic          done;
  logic          err;

  dircc_processing_mem_reader dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_byteenable (mem_byteenable),
    .mem_write      (mem_write),
    .mem_readdata   (mem_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [MW];
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= mem[int'(mem_address)];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  int            t_acc;
  int            done_cyc;
  int            done_err;
  int            done_cnt;
  int            issued;
  int            beats;
  int            max_out;
  int            valid_seen;
  logic [DW-1:0] bdata [$];
  logic          bsop  [$];
  logic          beop  [$];
  int            bcyc  [$];
  logic [AW-1:0] alog  [$];

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) t_acc = cyc;
    if (mem_chipselect) begin
      alog.push_back(mem_address);
      issued++;
    end
    if (st_valid) valid_seen++;
    if (st_valid && st_ready) begin
      bdata.push_back(st_data);
      bsop.push_back(st_sop);
      beop.push_back(st_eop);
      bcyc.push_back(cyc);
      beats++;
    end
    if (issued - beats > max_out) max_out = issued - beats;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = int'(err);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    bdata.delete(); bsop.delete(); beop.delete(); bcyc.delete(); alog.delete();
    issued = 0; beats = 0; max_out = 0; valid_seen = 0; done_cnt = 0;
    done_cyc = -1; done_err = -1; t_acc = -1000;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) check_eq("cmd_accept", 0, 1);
  endtask

  task automatic wait_done(input int bound);
    bit got;
    got = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    #1;
    check_eq("done_seen", 32'(got), 1);
  endtask

  // Compares the captured beats against base+i with SOP/EOP on the ends.
  task automatic check_packet(input string tag, input int n, input logic [DW-1:0] base);
    check_eq({tag, "_beats"}, beats, n);
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_data"}, (i < bdata.size()) ? 32'(bdata[i]) : 32'hDEAD, 32'(base + DW'(i)));
      check_eq({tag, "_sop"}, (i < bsop.size()) ? 32'(bsop[i]) : 32'hDEAD, 32'(i == 0));
      check_eq({tag, "_eop"}, (i < beop.size()) ? 32'(beop[i]) : 32'hDEAD, 32'(i == n - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    for (int i = 0; i < int'(MW); i++) mem[i] = DW'(i);
    mem[16'h0010] = 16'hBEEF;
    mem[20478]    = 16'hA001;
    mem[20479]    = 16'hA002;
    mem[0]        = 16'hC000;
    mem[1]        = 16'hC001;

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; st_ready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    check_eq("rst_st_valid", 32'(st_valid), 0);
    check_eq("rst_chipselect", 32'(mem_chipselect), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("tie_write", 32'(mem_write), 0);
    check_eq("tie_byteen", 32'(mem_byteenable), 3);
    check_eq("tie_clken", 32'(mem_clken), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Single word
    clear_mon();
    send_cmd(15'h0010, 8'd1);
    wait_done(30);
    check_packet("single", 1, 16'hBEEF);
    check_eq("single_beat_lat", (bcyc.size() > 0) ? 32'(bcyc[0] - t_acc) : 32'hDEAD, 3);
    check_eq("single_done_lat", 32'(done_cyc - t_acc), 4);
    check_eq("single_err", 32'(done_err), 0);
    @(negedge clk);
    check_eq("single_ready_back", 32'(cmd_ready), 1);

    // Burst
    clear_mon();
    send_cmd(15'h0100, 8'd8);
    wait_done(40);
    check_packet("burst", 8, 16'h0100);
    for (int i = 0; i < 8; i++) begin
      check_eq("burst_beat_cyc", (i < bcyc.size()) ? 32'(bcyc[i] - t_acc) : 32'hDEAD, 32'(3 + i));
    end
    check_eq("burst_done_lat", 32'(done_cyc - t_acc), 11);
    check_eq("burst_err", 32'(done_err), 0);

    // Backpressure
    clear_mon();
    st_ready = 1'b1;
    send_cmd(15'h0200, 8'd16);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (st_valid) begin
        seen = 1;
        break;
      end
    end
    check_eq("bp_first_valid", 32'(seen), 1);
    @(posedge clk); #1;
    st_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      st_ready = (i % 2 == 0);
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    #1;
    st_ready = 1'b1;
    check_eq("bp_done_seen", 32'(seen), 1);
    check_packet("bp", 16, 16'h0200);
    check_eq("bp_max_outstanding", 32'(max_out), FD);
    check_eq("bp_issued", 32'(issued), 16);
    check_eq("bp_done_cnt", 32'(done_cnt), 1);

    // Address wrap
    clear_mon();
    send_cmd(15'd20478, 8'd4);
    wait_done(30);
    check_eq("wrap_n_addr", 32'(alog.size()), 4);
    check_eq("wrap_a0", (alog.size() > 0) ? 32'(alog[0]) : 32'hDEAD, 20478);
    check_eq("wrap_a1", (alog.size() > 1) ? 32'(alog[1]) : 32'hDEAD, 20479);
    check_eq("wrap_a2", (alog.size() > 2) ? 32'(alog[2]) : 32'hDEAD, 0);
    check_eq("wrap_a3", (alog.size() > 3) ? 32'(alog[3]) : 32'hDEAD, 1);
    check_eq("wrap_d0", (bdata.size() > 0) ? 32'(bdata[0]) : 32'hDEAD, 32'hA001);
    check_eq("wrap_d1", (bdata.size() > 1) ? 32'(bdata[1]) : 32'hDEAD, 32'hA002);
    check_eq("wrap_d2", (bdata.size() > 2) ? 32'(bdata[2]) : 32'hDEAD, 32'hC000);
    check_eq("wrap_d3", (bdata.size() > 3) ? 32'(bdata[3]) : 32'hDEAD, 32'hC001);

    // Zero length
    clear_mon();
    send_cmd(15'h0005, 8'd0);
    wait_done(10);
    check_eq("zero_done_lat", 32'(done_cyc - t_acc), 1);
    check_eq("zero_err", 32'(done_err), 1);
    @(negedge clk);
    check_eq("zero_ready_back", 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("zero_no_reads", 32'(issued), 0);
    check_eq("zero_no_valid", 32'(valid_seen), 0);

    // Reset in the middle of a burst
    clear_mon();
    send_cmd(15'h0300, 8'd8);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (beats >= 3) begin
        seen = 1;
        break;
      end
    end
    check_eq("mid_third_beat", 32'(seen), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(st_valid), 0);
    check_eq("mid_rst_sop_eop", 32'({st_sop, st_eop}), 0);
    check_eq("mid_rst_data", 32'(st_data), 0);
    check_eq("mid_rst_cs", 32'(mem_chipselect), 0);
    check_eq("mid_rst_addr", 32'(mem_address), 0);
    check_eq("mid_rst_done_err", 32'({done, err}), 0);
    check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_eq("mid_no_done", 32'(done_cnt), 0);
    check_eq("mid_beats_stop", 32'(beats), 3);
    check_eq("mid_ready_back", 32'(cmd_ready), 1);
    clear_mon();
    send_cmd(15'h0400, 8'd2);
    wait_done(30);
    check_packet("after_rst", 2, 16'h0400);
    check_eq("after_rst_err", 32'(done_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
